// File: rtl/car_call_latch.sv
// rtl/car_call_latch.sv - in-car floor-call register with button synchronisers and dwell-based service clear
//
// Holds one call bit per floor. Raw panel buttons are synchronised (2 flops),
// rising-edge detected and latched. A call clears once the car has been stopped
// at that floor for DWELL_CYC consecutive cycles, producing a one-cycle served
// pulse with the floor index.
//
// Optional feature macro: CALL_CANCEL_EN (press on a lit floor toggles it off).
//
// Ports:
//   clk           in   1        system clock
//   rst_n         in   1        asynchronous active-low reset
//   press         in   FLOORS   raw button levels, asynchronous to clk
//   cur_floor     in   FLOOR_W  current car floor, 0-based
//   moving        in   1        1 = car in motion, 0 = stopped at cur_floor
//   call          out  FLOORS   latched calls
//   pending       out  1        OR of call, one cycle behind call
//   served        out  1        one-cycle pulse when a call clears by service
//   served_floor  out  FLOOR_W  floor cleared, valid with served, held otherwise
module car_call_latch #(
  parameter int FLOORS    = 4,
  parameter int FLOOR_W   = 2,
  parameter int DWELL_CYC = 100000000,
  parameter int CNT_W     = 27
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FLOORS-1:0]  press,
  input  logic [FLOOR_W-1:0] cur_floor,
  input  logic               moving,
  output logic [FLOORS-1:0]  call,
  output logic               pending,
  output logic               served,
  output logic [FLOOR_W-1:0] served_floor
);

  typedef enum logic {IDLE, DWELL} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYC - 1);

  state_t             state, state_n;
  logic [FLOORS-1:0]  sync1, sync2, prev;
  logic [FLOORS-1:0]  rise, here_mask, clear_mask, set_mask, cancel_mask, call_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [FLOOR_W-1:0] dwell_floor, dwell_floor_n;
  logic               floor_valid, at_call, served_n;

  assign rise        = sync2 & ~prev;
  assign floor_valid = 32'(cur_floor) < FLOORS;
  // Car is stopped at a real floor that currently has a lit call.
  assign at_call     = floor_valid && !moving && call[cur_floor];

  // Floor the stopped car is sitting at; presses there cannot raise a new call.
  always_comb begin
    here_mask = '0;
    if (floor_valid && !moving) here_mask[cur_floor] = 1'b1;
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    dwell_floor_n = dwell_floor;
    clear_mask    = '0;
    served_n      = 1'b0;
    if (state == IDLE) begin
      if (at_call) begin
        state_n       = DWELL;
        cnt_n         = '0;
        dwell_floor_n = cur_floor;
      end
    end else begin
      // Any loss of the stopped-at-lit-floor condition aborts without clearing.
      if (!at_call || cur_floor != dwell_floor) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else if (cnt == CNT_LAST) begin
        clear_mask[cur_floor] = 1'b1;
        served_n              = 1'b1;
        state_n               = IDLE;
        cnt_n                 = '0;
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    set_mask = rise & ~call & ~here_mask;
`ifdef CALL_CANCEL_EN
    cancel_mask = rise & call;
`else
    cancel_mask = '0;
`endif
    // Service clear is applied last so it wins over a same-cycle press.
    call_n = ((call & ~cancel_mask) | set_mask) & ~clear_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1        <= '0;
      sync2        <= '0;
      prev         <= '0;
      cnt          <= '0;
      dwell_floor  <= '0;
      call         <= '0;
      pending      <= 1'b0;
      served       <= 1'b0;
      served_floor <= '0;
    end else begin
      sync1       <= press;
      sync2       <= sync1;
      prev        <= sync2;
      cnt         <= cnt_n;
      dwell_floor <= dwell_floor_n;
      call        <= call_n;
      pending     <= |call;
      served      <= served_n;
      if (served_n) served_floor <= cur_floor;
    end
  end

endmodule
